modulo_updown_counter: RTL and testbench

Runtime-programmable modulo counter with up/down direction, parallel load, synchronous clear and a terminal-count output suited to cascading. It generalises the fixed-modulus counter: modulus is an input (1..MAX_N) rather than elaboration-time only. It sits in the Sequential library as the timebase/prescaler primitive for dividers, timers and digit chains.

---
 rtl/modulo_updown_counter.sv | 69 ++++++
 tb/tb_modulo_updown_counter.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/modulo_updown_counter.sv
// Runtime-programmable modulo up/down counter with load, sync clear and cascadable
// terminal count. Modulus is mod_m1+1, selectable per cycle from 1 to MAX_N.
module modulo_updown_counter #(
    parameter  int MAX_N = 16,
    localparam int WIDTH = (MAX_N > 1) ? $clog2(MAX_N) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             up,
    input  logic [WIDTH-1:0] mod_m1,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap
);

    logic [WIDTH-1:0] count_next;
    logic             at_top;
    logic             at_bottom;
    logic             step;

    assign at_top    = (count == mod_m1);
    assign at_bottom = (count == '0);
    assign step      = en && !clr && !load;

    // Out-of-range counts (count > mod_m1) match neither terminal, so they never raise tc.
    assign tc = rst && step && ((up && at_top) || (!up && at_bottom));

    always_comb begin
        // NOTE: default assigned first so every path drives count_next and no latch is inferred.
        count_next = count;
        if (clr) begin
            count_next = '0;
        end else if (load) begin
            count_next = load_val;
        end else if (en) begin
            if (up) begin
                if (at_top)
                    count_next = '0;
                else if (count < mod_m1)
                    count_next = count + 1'b1;
                else
                    count_next = '0;
            end else begin
                if (at_bottom)
                    count_next = mod_m1;
                else if (count <= mod_m1)
                    count_next = count - 1'b1;
                else
                    count_next = mod_m1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
            wrap  <= 1'b0;
        end else begin
            count <= count_next;
            wrap  <= tc;
        end
    end

endmodule

// File: tb/tb_modulo_updown_counter.sv
// Table-driven self-checking bench for modulo_updown_counter (MAX_N=16),
// with hand-written sequences for asynchronous reset behaviour.
module tb_modulo_updown_counter;

    localparam int MAX_N = 16;
    localparam int WIDTH = 4;

    logic             clk;
    logic             rst;
    logic             clr;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             en;
    logic             up;
    logic [WIDTH-1:0] mod_m1;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             wrap;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       clr;
        logic       load;
        logic [3:0] lv;
        logic       en;
        logic       up;
        logic [3:0] m;
        logic       e_tc;
        logic [3:0] e_cnt;
        logic       e_wrap;
        string      tag;
    } vec_t;

    vec_t vecs[$];

    modulo_updown_counter #(.MAX_N(MAX_N)) dut (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .load     (load),
        .load_val (load_val),
        .en       (en),
        .up       (up),
        .mod_m1   (mod_m1),
        .count    (count),
        .tc       (tc),
        .wrap     (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic void add(input logic c, input logic l, input logic [3:0] lv,
                                input logic e, input logic u, input logic [3:0] m,
                                input logic etc, input logic [3:0] ecnt, input logic ew,
                                input string tag);
        vec_t v;
        v.clr = c; v.load = l; v.lv = lv; v.en = e; v.up = u; v.m = m;
        v.e_tc = etc; v.e_cnt = ecnt; v.e_wrap = ew; v.tag = tag;
        vecs.push_back(v);
    endfunction

    // Drive inputs just after a rising edge, check tc before the next edge,
    // then check count/wrap just after it.
    task automatic run_vec(input vec_t v);
        clr = v.clr; load = v.load; load_val = v.lv; en = v.en; up = v.up; mod_m1 = v.m;
        @(negedge clk);
        check({v.tag, ".tc"}, 32'(tc), 32'(v.e_tc));
        @(posedge clk);
        #1;
        check({v.tag, ".count"}, 32'(count), 32'(v.e_cnt));
        check({v.tag, ".wrap"}, 32'(wrap), 32'(v.e_wrap));
    endtask

    initial begin
        vec_t v;

        // Up count, modulus 10, 25 edges from reset.
        for (int k = 1; k <= 25; k++)
            add(0, 0, 0, 1, 1, 9, ((k - 1) % 10) == 9, 4'(k % 10), ((k - 1) % 10) == 9,
                $sformatf("up%0d", k));
        add(1, 0, 0, 1, 1, 9, 0, 0, 0, "clr_mid");
        // Down count from 0, modulus 10: 9,8,...,0,9.
        for (int k = 1; k <= 11; k++)
            add(0, 0, 0, 1, 0, 9, (k == 1 || k == 11), 4'((20 - k) % 10), (k == 1 || k == 11),
                $sformatf("dn%0d", k));
        add(0, 1, 13, 1, 1, 9, 0, 13, 0, "load_at_tc");
        add(0, 0, 0,  1, 1, 9, 0, 0,  0, "oor_up");
        add(0, 1, 13, 0, 0, 9, 0, 13, 0, "load13b");
        add(0, 0, 0,  1, 0, 9, 0, 9,  0, "oor_dn");
        add(0, 1, 9,  0, 1, 9, 0, 9,  0, "load9");
        add(1, 1, 5,  1, 1, 9, 0, 0,  0, "clr_load_en");
        add(0, 0, 0,  1, 1, 9, 0, 1,  0, "post_clr1");
        add(0, 0, 0,  1, 1, 9, 0, 2,  0, "post_clr2");
        add(0, 0, 0,  1, 1, 9, 0, 3,  0, "post_clr3");
        add(0, 0, 0,  1, 1, 9, 0, 4,  0, "post_clr4");
        add(0, 0, 0,  0, 1, 9, 0, 4,  0, "hold1");
        add(0, 0, 0,  0, 1, 9, 0, 4,  0, "hold2");
        add(0, 0, 0,  1, 1, 3, 0, 0,  0, "mod_shrink");
        add(0, 0, 0,  1, 1, 3, 0, 1,  0, "mod3_step");
        add(0, 0, 0,  1, 1, 0, 0, 0,  0, "mod1_recover");
        for (int k = 1; k <= 5; k++)
            add(0, 0, 0, 1, 1, 0, 1, 0, 1, $sformatf("mod1_up%0d", k));
        add(0, 0, 0,  1, 0, 0, 1, 0,  1, "mod1_dn");
        add(0, 0, 0,  0, 0, 0, 0, 0,  0, "mod1_idle");
        add(0, 1, 15, 0, 1, 15, 0, 15, 0, "load15");
        add(0, 0, 0,  1, 1, 15, 1, 0,  1, "mod16_wrap_up");
        add(0, 0, 0,  1, 0, 15, 1, 15, 1, "mod16_wrap_dn");
        add(0, 0, 0,  0, 0, 15, 0, 15, 0, "mod16_idle");

        // Reset state; tc forced low even with a qualifying input pattern.
        rst = 1'b0; clr = 1'b0; load = 1'b0; load_val = '0; en = 1'b1; up = 1'b0; mod_m1 = 4'd9;
        #1;
        check("rst.count", 32'(count), 0);
        check("rst.wrap", 32'(wrap), 0);
        check("rst.tc", 32'(tc), 0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_hold.count", 32'(count), 0);
        en = 1'b0;
        rst = 1'b1;

        foreach (vecs[i]) run_vec(vecs[i]);

        // Reset asserted while a wrap pulse is in flight.
        v = '{clr: 0, load: 1, lv: 9, en: 0, up: 1, m: 9, e_tc: 0, e_cnt: 9, e_wrap: 0, tag: "pre_wrap"};
        run_vec(v);
        v = '{clr: 0, load: 0, lv: 0, en: 1, up: 1, m: 9, e_tc: 1, e_cnt: 0, e_wrap: 1, tag: "wrap_edge"};
        run_vec(v);
        #2 rst = 1'b0;
        #1;
        check("async_rst.wrap", 32'(wrap), 0);
        check("async_rst.count", 32'(count), 0);
        #1 rst = 1'b1;

        // Count to 7, then reset between edges.
        en = 1'b1; up = 1'b1; mod_m1 = 4'd9;
        repeat (7) @(posedge clk);
        #1;
        check("to7.count", 32'(count), 7);
        #2 rst = 1'b0;
        #1;
        check("rst7.count", 32'(count), 0);
        check("rst7.wrap", 32'(wrap), 0);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst.count", 32'(count), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
